// File: rtl/instr_sequencer.sv
// Fetch/execute controller for the 2-bit instruction ROM: runs INC / JNO / HLT
// against an internal accumulator from address 0 until HLT, then reports completion.
module instr_sequencer #(
    parameter int ACC_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             instr_msb,
    input  logic             instr_lsb,
    output logic             sel1,
    output logic             sel2,
    output logic [ACC_W-1:0] acc,
    output logic             ovf,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_e;

    typedef enum logic [1:0] {
        OP_INC = 2'b00,
        OP_JNO = 2'b01,
        OP_HLT = 2'b10,
        OP_NOP = 2'b11
    } opcode_e;

    state_e           state_q, state_d;
    opcode_e          ir_q, ir_d;
    logic [1:0]       pc_q, pc_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W:0]   acc_inc;
    logic [CNT_W-1:0] cnt_sat;

    assign acc_inc = {1'b0, acc_q} + {{ACC_W{1'b0}}, 1'b1};
    assign cnt_sat = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        case (state_q)
            // IDLE and HALT share the launch path; a restart from HALT is a full restart.
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = 2'd0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                ir_d    = opcode_e'({instr_msb, instr_lsb});
                state_d = S_EXEC;
            end
            S_EXEC: begin
                cnt_d   = cnt_sat;
                state_d = S_FETCH;
                case (ir_q)
                    OP_INC: begin
                        acc_d = acc_inc[ACC_W-1:0];
                        ovf_d = acc_inc[ACC_W];
                        pc_d  = pc_q + 2'd1;
                    end
                    OP_JNO: begin
                        pc_d = ovf_q ? pc_q + 2'd1 : 2'd0;
                    end
                    OP_HLT: begin
                        state_d = S_HALT;
                    end
                    default: begin
                        pc_d = pc_q + 2'd1;
                    end
                endcase
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ir_q    <= OP_INC;
            pc_q    <= 2'd0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel1        = pc_q[0];
    assign sel2        = pc_q[1];
    assign acc         = acc_q;
    assign ovf         = ovf_q;
    assign instr_count = cnt_q;
    assign busy        = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: an ISA-level interpreter of the ROM program
// predicts every fetch and the halt result; a negedge monitor compares.
module tb_instr_sequencer;

    localparam int ACC_W  = 4;
    localparam int CNT_W  = 8;
    localparam int ACCMOD = 1 << ACC_W;
    localparam int CNTMAX = (1 << CNT_W) - 1;

    typedef struct {
        int addr;
        int acc;
        int ovf;
        int cnt;
    } fetch_t;

    typedef struct {
        int acc;
        int ovf;
        int cnt;
        int haltCycle;
    } final_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             instr_msb, instr_lsb;
    logic             sel1, sel2;
    logic [ACC_W-1:0] acc;
    logic             ovf, busy, halted;
    logic [CNT_W-1:0] instr_count;

    logic [1:0] rom [4];
    fetch_t     fetchQ[$];
    final_t     finalQ[$];
    int         tests = 0;
    int         failed = 0;
    int         cyc = 0;
    bit         phase = 1'b0;
    bit         prevHalted = 1'b0;

    instr_sequencer #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .instr_msb(instr_msb), .instr_lsb(instr_lsb),
        .sel1(sel1), .sel2(sel2), .acc(acc), .ovf(ovf),
        .busy(busy), .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign {instr_msb, instr_lsb} = rom[{sel2, sel1}];

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Interprets the ROM program instruction by instruction and queues what each fetch should see.
    task automatic modelRun(input int base, input int limit, output int n, output bit halts);
        int     pc = 0;
        int     a = 0;
        int     o = 0;
        int     c = 0;
        fetch_t fe;
        final_t fi;
        n = 0;
        halts = 1'b0;
        while (n < limit && !halts) begin
            fe.addr = pc; fe.acc = a; fe.ovf = o; fe.cnt = c;
            fetchQ.push_back(fe);
            n++;
            c = (c < CNTMAX) ? c + 1 : c;
            case (int'(rom[pc]))
                0: begin
                    a = a + 1;
                    o = (a == ACCMOD) ? 1 : 0;
                    a = a % ACCMOD;
                    pc = (pc + 1) % 4;
                end
                1: pc = (o != 0) ? (pc + 1) % 4 : 0;
                2: halts = 1'b1;
                default: pc = (pc + 1) % 4;
            endcase
        end
        if (halts) begin
            fi.acc = a; fi.ovf = o; fi.cnt = c; fi.haltCycle = base + 2 * n;
            finalQ.push_back(fi);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        fetchQ.delete();
        finalQ.delete();
        #1;
        checkOutput("reset acc", acc, 0);
        checkOutput("reset ovf", ovf, 0);
        checkOutput("reset sel", {sel2, sel1}, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset halted", halted, 0);
        checkOutput("reset count", instr_count, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Launches the current ROM program with a start pulse of 'width' cycles and waits for its outcome.
    task automatic applyStimulus(input int limit, input int width);
        int s, n;
        bit h;
        @(negedge clk);
        s = cyc + 1;
        modelRun(s, limit, n, h);
        start = 1'b1;
        repeat (width) @(negedge clk);
        start = 1'b0;
        if (h) begin
            while (cyc < s + 2 * n + 1) @(negedge clk);
            checkOutput("halt holds", halted, 1);
            checkOutput("halt not busy", busy, 0);
        end else begin
            while (cyc < s + 2 * limit - 1) @(negedge clk);
            #2 doReset();
        end
        checkOutput("scoreboard drained", fetchQ.size() + finalQ.size(), 0);
    endtask

    always @(negedge clk) begin
        fetch_t fe;
        final_t fi;
        if (busy) begin
            if (!phase) begin
                if (fetchQ.size() == 0) begin
                    tests++; failed++;
                    $display("[TB] FAIL unexpected fetch: addr %0d, expected no activity", {sel2, sel1});
                end else begin
                    fe = fetchQ.pop_front();
                    checkOutput("fetch addr", {sel2, sel1}, fe.addr);
                    checkOutput("fetch acc", acc, fe.acc);
                    checkOutput("fetch ovf", ovf, fe.ovf);
                    checkOutput("fetch count", instr_count, fe.cnt);
                end
            end
            phase = !phase;
        end else begin
            phase = 1'b0;
        end
        if (halted && !prevHalted) begin
            if (finalQ.size() == 0) begin
                tests++; failed++;
                $display("[TB] FAIL unexpected halt: halted 1, expected 0");
            end else begin
                fi = finalQ.pop_front();
                checkOutput("halt cycle", cyc, fi.haltCycle);
                checkOutput("halt acc", acc, fi.acc);
                checkOutput("halt ovf", ovf, fi.ovf);
                checkOutput("halt count", instr_count, fi.cnt);
                checkOutput("halt busy", busy, 0);
            end
        end
        prevHalted = halted;
    end

    initial begin
        int s, s2, n;
        bit h;

        rom[0] = 2'b00; rom[1] = 2'b01; rom[2] = 2'b00; rom[3] = 2'b10;
        repeat (2) @(negedge clk);
        doReset();

        // Standard program, then a restart from HALT.
        applyStimulus(200, 1);
        checkOutput("std count", instr_count, 2 * ACCMOD + 2);
        checkOutput("std acc", acc, 1);
        applyStimulus(200, 1);

        // Start held across the whole run: one restart, on the first HALT cycle.
        @(negedge clk);
        s = cyc + 1;
        modelRun(s, 200, n, h);
        s2 = s + 2 * n + 1;
        modelRun(s2, 200, n, h);
        start = 1'b1;
        while (cyc < s2 + 2 * n) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("hold halted", halted, 1);
        checkOutput("hold drained", fetchQ.size() + finalQ.size(), 0);

        // Reset during the EXEC of the sixth INC, when acc is 5.
        @(negedge clk);
        s = cyc + 1;
        modelRun(s, 200, n, h);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + 21) @(negedge clk);
        #2;
        checkOutput("pre-reset acc", acc, 5);
        doReset();
        repeat (10) @(negedge clk);
        checkOutput("idle after reset busy", busy, 0);
        checkOutput("idle after reset acc", acc, 0);
        checkOutput("idle after reset sel", {sel2, sel1}, 0);

        // Random programs and start pulse widths.
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 4; i++) rom[i] = 2'($urandom_range(0, 3));
            applyStimulus(40, int'($urandom_range(1, 3)));
        end

        // All-reserved program never halts and saturates the counter.
        for (int i = 0; i < 4; i++) rom[i] = 2'b11;
        applyStimulus(300, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
